// File: rtl/random_perm3_seq_ctrl.sv
// Draws one random permutation of a 3-element, 2-bit-per-element set from a free-running
// 7-bit LFSR and streams the permuted elements out over a valid/ready handshake.
module random_perm3_seq_ctrl #(
  parameter logic [6:0]  SEED  = 7'h5A,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_we,
  input  logic [6:0]       seed_in,
  input  logic             start,
  output logic             start_rdy,
  input  logic [5:0]       x_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_data,
  output logic             out_last,
  output logic             busy,
  output logic [CNT_W-1:0] seq_count
);

  // An all-zero state would lock the LFSR up, so zero seeds load as 1.
  localparam logic [6:0] SeedInit = (SEED == 7'h00) ? 7'h01 : SEED;

  typedef enum logic [1:0] {StIdle, StDraw, StEmit} state_e;

  state_e           state_q, state_d;
  logic [6:0]       lfsr_q, lfsr_d;
  logic [5:0]       x_q, x_d;
  logic [6:0]       rnd_q, rnd_d;
  logic [5:0]       y_q, y_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       y_map;
  logic [1:0]       e0, e1, e2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      lfsr_q  <= SeedInit;
      x_q     <= '0;
      rnd_q   <= '0;
      y_q     <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      x_q     <= x_d;
      rnd_q   <= rnd_d;
      y_q     <= y_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // y_map packs {Y2, Y1, Y0}; six near-equal bands of the 7-bit select pick the permutation.
  always_comb begin
    e0 = x_q[1:0];
    e1 = x_q[3:2];
    e2 = x_q[5:4];
    if (rnd_q <= 7'd20) begin
      y_map = {e2, e1, e0};
    end else if (rnd_q <= 7'd41) begin
      y_map = {e1, e2, e0};
    end else if (rnd_q <= 7'd63) begin
      y_map = {e2, e0, e1};
    end else if (rnd_q <= 7'd84) begin
      y_map = {e1, e0, e2};
    end else if (rnd_q <= 7'd105) begin
      y_map = {e0, e2, e1};
    end else begin
      y_map = {e0, e1, e2};
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    rnd_d   = rnd_q;
    y_d     = y_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;

    // Reseed wins over the advance; the accept below still samples the pre-reseed value.
    if (seed_we) begin
      lfsr_d = (seed_in == 7'h00) ? 7'h01 : seed_in;
    end else begin
      lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StDraw;
          x_d     = x_in;
          rnd_d   = lfsr_q;
        end
      end
      StDraw: begin
        state_d = StEmit;
        y_d     = y_map;
        idx_d   = 2'd0;
      end
      StEmit: begin
        if (out_ready) begin
          if (idx_q == 2'd2) begin
            state_d = StIdle;
            idx_d   = 2'd0;
            cnt_d   = cnt_q + 1'b1;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    start_rdy = (state_q == StIdle);
    busy      = (state_q == StDraw) || (state_q == StEmit);
    out_valid = (state_q == StEmit);
    out_last  = out_valid && (idx_q == 2'd2);
    out_data  = 2'b00;
    if (out_valid) begin
      case (idx_q)
        2'd0:    out_data = y_q[1:0];
        2'd1:    out_data = y_q[3:2];
        default: out_data = y_q[5:4];
      endcase
    end
    seq_count = cnt_q;
  end

endmodule

// File: tb/tb_random_perm3_seq_ctrl.sv
// Self-checking bench for random_perm3_seq_ctrl: vector table of seeds/expected orders,
// hand-written corner sequences, and a randomized run against a behavioural reference model.
module tb_random_perm3_seq_ctrl;

  localparam int         CW   = 3;
  localparam logic [6:0] SEED = 7'h5A;

  logic          clk;
  logic          rst;
  logic          seed_we;
  logic [6:0]    seed_in;
  logic          start;
  logic          start_rdy;
  logic [5:0]    x_in;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    out_data;
  logic          out_last;
  logic          busy;
  logic [CW-1:0] seq_count;

  random_perm3_seq_ctrl #(
    .SEED  (SEED),
    .CNT_W (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .seed_we   (seed_we),
    .seed_in   (seed_in),
    .start     (start),
    .start_rdy (start_rdy),
    .x_in      (x_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .seq_count (seq_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: pending/emitting flags, a queue of elements still to deliver.
  bit m_draw;
  bit m_emit;
  int m_q[$];
  int m_lfsr;
  int m_cnt;

  // For each band, the input slot that supplies output slot 0, 1, 2.
  int src[6][3] = '{'{0, 1, 2}, '{0, 2, 1}, '{1, 0, 2}, '{2, 0, 1}, '{1, 2, 0}, '{2, 1, 0}};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int lfsr_next(input int l);
    return ((l << 1) & 127) | (((l >> 6) ^ (l >> 5)) & 1);
  endfunction

  function automatic int band_of(input int r);
    if (r < 21) return 0;
    if (r < 42) return 1;
    if (r < 64) return 2;
    if (r < 85) return 3;
    if (r < 106) return 4;
    return 5;
  endfunction

  task automatic model_reset();
    m_draw = 1'b0;
    m_emit = 1'b0;
    m_q.delete();
    m_lfsr = int'(SEED);
    m_cnt  = 0;
  endtask

  task automatic model_edge();
    int nl;
    int b;
    if (rst) begin
      model_reset();
    end else begin
      nl = seed_we ? ((seed_in == 7'h00) ? 1 : int'(seed_in)) : lfsr_next(m_lfsr);
      if (!m_draw && !m_emit) begin
        if (start) begin
          b = band_of(m_lfsr);
          for (int j = 0; j < 3; j++) m_q.push_back((int'(x_in) >> (2 * src[b][j])) & 3);
          m_draw = 1'b1;
        end
      end else if (m_draw) begin
        m_draw = 1'b0;
        m_emit = 1'b1;
      end else if (out_ready) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) begin
          m_emit = 1'b0;
          m_cnt  = (m_cnt + 1) % (1 << CW);
        end
      end
      m_lfsr = nl;
    end
  endtask

  function automatic logic [15:0] model_vec();
    logic       idle;
    int         head;
    logic [1:0] d;
    logic [2:0] c;
    logic [6:0] l;
    idle = !m_draw && !m_emit;
    head = m_emit ? m_q[0] : 0;
    d    = head[1:0];
    c    = m_cnt[2:0];
    l    = m_lfsr[6:0];
    return {idle, !idle, m_emit, d, m_emit && (m_q.size() == 1), c, l};
  endfunction

  function automatic logic [15:0] dut_vec();
    return {start_rdy, busy, out_valid, out_data, out_last, seq_count, dut.lfsr_q};
  endfunction

  // Compare at the negedge, then let one rising edge happen and step the model with it.
  task automatic cycle(input string tag);
    check(tag, 32'(dut_vec()), 32'(model_vec()));
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic reseed_and_start(input logic [6:0] s, input logic [5:0] x);
    seed_we = 1'b1;
    seed_in = s;
    cycle("seed");
    seed_we = 1'b0;
    start   = 1'b1;
    x_in    = x;
    cycle("accept");
    start   = 1'b0;
    x_in    = 6'($urandom);
  endtask

  typedef struct {
    logic [6:0] seed;
    logic [5:0] x;
    int         d0;
    int         d1;
    int         d2;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int lat;
    int n;
    int guard;
    int got[3];
    int c0;

    vecs[0]  = '{7'd10,  6'b10_01_00, 0, 1, 2};
    vecs[1]  = '{7'd30,  6'b10_01_00, 0, 2, 1};
    vecs[2]  = '{7'd100, 6'b10_01_00, 1, 2, 0};
    vecs[3]  = '{7'd0,   6'b10_01_00, 0, 1, 2};
    vecs[4]  = '{7'd20,  6'b10_01_00, 0, 1, 2};
    vecs[5]  = '{7'd21,  6'b10_01_00, 0, 2, 1};
    vecs[6]  = '{7'd41,  6'b10_01_00, 0, 2, 1};
    vecs[7]  = '{7'd42,  6'b10_01_00, 1, 0, 2};
    vecs[8]  = '{7'd63,  6'b10_01_00, 1, 0, 2};
    vecs[9]  = '{7'd64,  6'b10_01_00, 2, 0, 1};
    vecs[10] = '{7'd84,  6'b10_01_00, 2, 0, 1};
    vecs[11] = '{7'd85,  6'b10_01_00, 1, 2, 0};
    vecs[12] = '{7'd105, 6'b10_01_00, 1, 2, 0};
    vecs[13] = '{7'd106, 6'b10_01_00, 2, 1, 0};
    vecs[14] = '{7'd127, 6'b10_01_00, 2, 1, 0};
    vecs[15] = '{7'd30,  6'b11_00_10, 2, 3, 0};

    rst       = 1'b1;
    seed_we   = 1'b0;
    seed_in   = 7'd0;
    start     = 1'b0;
    x_in      = 6'd0;
    out_ready = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("reset_start_rdy", 32'(start_rdy), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_seq_count", 32'(seq_count), 32'd0);
    cycle("reset");
    rst = 1'b0;

    // LFSR period: back to SEED after 127 advances, never zero on the way.
    for (int i = 0; i < 127; i++) begin
      check("lfsr_nonzero", 32'(dut.lfsr_q != 7'd0), 32'd1);
      cycle("freerun");
    end
    check("lfsr_period", 32'(dut.lfsr_q), 32'(SEED));

    for (int v = 0; v < 16; v++) begin
      reseed_and_start(vecs[v].seed, vecs[v].x);
      lat = 0;
      while (!out_valid && lat < 8) begin
        cycle("draw");
        lat++;
      end
      check("latency", 32'(lat), 32'd1);
      n     = 0;
      guard = 0;
      got   = '{-1, -1, -1};
      while (n < 3 && guard < 10) begin
        if (out_valid) begin
          got[n] = int'(out_data);
          check("out_last", 32'(out_last), 32'(n == 2));
          n++;
        end
        cycle("emit");
        guard++;
      end
      check("elem0", 32'(got[0]), 32'(vecs[v].d0));
      check("elem1", 32'(got[1]), 32'(vecs[v].d1));
      check("elem2", 32'(got[2]), 32'(vecs[v].d2));
      check("idle_after", 32'(start_rdy), 32'd1);
    end

    // Backpressure: first element held for 5 cycles, then the rest without loss.
    reseed_and_start(7'd30, 6'b10_01_00);
    cycle("draw");
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", 32'(out_data), 32'd0);
      check("bp_last", 32'(out_last), 32'd0);
      cycle("bp_hold");
    end
    out_ready = 1'b1;
    n = 0;
    guard = 0;
    got = '{-1, -1, -1};
    while (n < 3 && guard < 10) begin
      if (out_valid) begin
        got[n] = int'(out_data);
        n++;
      end
      cycle("bp_emit");
      guard++;
    end
    check("bp_elem0", 32'(got[0]), 32'd0);
    check("bp_elem1", 32'(got[1]), 32'd2);
    check("bp_elem2", 32'(got[2]), 32'd1);
    check("bp_no_extra", 32'(out_valid), 32'd0);

    // start held high while busy is ignored; exactly one sequence completes.
    c0 = m_cnt;
    reseed_and_start(7'd10, 6'b10_01_00);
    guard = 0;
    start = 1'b1;
    while (busy && guard < 10) begin
      check("busy_start_rdy", 32'(start_rdy), 32'd0);
      start = !out_last;
      cycle("busy_start");
      guard++;
    end
    start = 1'b0;
    check("busy_count", 32'(seq_count), 32'((c0 + 1) % (1 << CW)));
    cycle("busy_idle");
    check("busy_not_queued", 32'(busy), 32'd0);

    // Reset in the middle of EMIT aborts the sequence.
    reseed_and_start(7'd30, 6'b10_01_00);
    cycle("draw");
    cycle("first_elem");
    check("mid_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    cycle("rst_mid");
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_seq_count", 32'(seq_count), 32'd0);
    check("rst_lfsr", 32'(dut.lfsr_q), 32'(SEED));
    check("rst_start_rdy", 32'(start_rdy), 32'd1);

    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(299) == 0);
      seed_we   = ($urandom_range(39) == 0);
      seed_in   = 7'($urandom);
      start     = ($urandom_range(2) == 0);
      x_in      = 6'($urandom);
      out_ready = ($urandom_range(3) != 0);
      cycle("rand");
    end
    rst     = 1'b0;
    seed_we = 1'b0;
    start   = 1'b0;
    cycle("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
